// File: rtl/netlist_eval_sched.sv
// Two-requester scheduler for a shared combinational netlist. It grants one
// requester, drives the operands into the datapath, waits SETTLE_CYC cycles
// for the netlist to settle, then samples dp_out and presents the result.
module netlist_eval_sched #(
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic             iccad_clk,
  input  logic             iccad_rst,
  input  logic             req0_valid,
  input  logic             req0_a,
  input  logic             req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_a,
  input  logic             req1_b,
  output logic             req1_ready,
  output logic             dp_inp1,
  output logic             dp_inp2,
  input  logic             dp_out,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_data,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [CNT_W-1:0] eval_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t     state, state_nxt;
  logic       ptr;      // 1: req1 preferred when both are valid
  logic [3:0] cnt;      // remaining settle cycles before sampling
  logic       gnt0, gnt1, hs, rsp_hs;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);
  assign hs         = gnt0 | gnt1;
  assign rsp_hs     = rsp_valid & rsp_ready;

  // Grant decode and next-state logic; grants only exist in IDLE.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        gnt0 = req0_valid & (~req1_valid | ~ptr);
        gnt1 = req1_valid & (~req0_valid |  ptr);
        if (gnt0 | gnt1) state_nxt = SETTLE;
      end
      SETTLE: if (cnt == 4'd0) state_nxt = RESP;
      RESP:   if (rsp_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iccad_clk or posedge iccad_rst) begin
    if (iccad_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  // Operand capture at grant, settle countdown and result sampling.
  always_ff @(posedge iccad_clk or posedge iccad_rst) begin
    if (iccad_rst) begin
      dp_inp1  <= 1'b0;
      dp_inp2  <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= 1'b0;
      cnt      <= 4'd0;
    end else if (hs) begin
      dp_inp1 <= gnt1 ? req1_a : req0_a;
      dp_inp2 <= gnt1 ? req1_b : req0_b;
      rsp_id  <= gnt1;
      cnt     <= 4'(SETTLE_CYC - 1);
    end else if (state == SETTLE) begin
      if (cnt != 4'd0) cnt      <= cnt - 4'd1;
      else             rsp_data <= dp_out;
    end
  end

  // Fairness pointer and completion counter advance on result acceptance.
  always_ff @(posedge iccad_clk or posedge iccad_rst) begin
    if (iccad_rst) begin
      ptr        <= 1'b0;
      eval_count <= '0;
    end else if (rsp_hs) begin
      ptr        <= ~rsp_id;
      eval_count <= eval_count + CNT_W'(1);
    end
  end

endmodule
